// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, default datapath widths and the
// packed control bundle carried from decode into EX.
package cpu_pkg;

  localparam int unsigned XLEN_DEFAULT   = 32;
  localparam int unsigned REG_AW_DEFAULT = 5;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_XOR  = 3'b001,
    ALU_SLL  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_SRAI = 3'b110
  } alu_op_e;

  typedef struct packed {
    logic    alu_src;
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    alu_op_e alu_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    alu_src:    1'b0,
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    alu_ctrl:   ALU_AND
  };

  typedef enum logic {
    ST_RUN,
    ST_MUL_HOLD
  } hold_state_e;

  // Only a real (valid) MUL occupies EX for more than one cycle.
  function automatic logic starts_hold(logic valid, logic [2:0] alu);
    return valid && (alu == ALU_MUL);
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode-to-EX bundle: decoded fields and hazard/flush in, registered fields,
// valid, stall and EX/MEM fire out.
interface id_ex_reg_if
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned REG_AW = REG_AW_DEFAULT
);

  logic              hazard_i;
  logic              flush_i;
  logic              valid_i;
  logic [XLEN-1:0]   data1_i;
  logic [XLEN-1:0]   data2_i;
  logic [XLEN-1:0]   imm_i;
  logic [2:0]        alu_ctrl_i;
  logic              alu_src_i;
  logic              reg_write_i;
  logic              mem_to_reg_i;
  logic              mem_read_i;
  logic              mem_write_i;
  logic [REG_AW-1:0] rs1_i;
  logic [REG_AW-1:0] rs2_i;
  logic [REG_AW-1:0] rd_i;

  logic [XLEN-1:0]   data1_o;
  logic [XLEN-1:0]   data2_o;
  logic [XLEN-1:0]   imm_o;
  logic [2:0]        alu_ctrl_o;
  logic              alu_src_o;
  logic              reg_write_o;
  logic              mem_to_reg_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [REG_AW-1:0] rs1_o;
  logic [REG_AW-1:0] rs2_o;
  logic [REG_AW-1:0] rd_o;
  logic              valid_o;
  logic              stall_o;
  logic              ex_fire_o;

  modport master (
    output hazard_i, flush_i, valid_i, data1_i, data2_i, imm_i, alu_ctrl_i,
           alu_src_i, reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i,
           rs1_i, rs2_i, rd_i,
    input  data1_o, data2_o, imm_o, alu_ctrl_o, alu_src_o, reg_write_o,
           mem_to_reg_o, mem_read_o, mem_write_o, rs1_o, rs2_o, rd_o,
           valid_o, stall_o, ex_fire_o
  );

  modport slave (
    input  hazard_i, flush_i, valid_i, data1_i, data2_i, imm_i, alu_ctrl_i,
           alu_src_i, reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i,
           rs1_i, rs2_i, rd_i,
    output data1_o, data2_o, imm_o, alu_ctrl_o, alu_src_o, reg_write_o,
           mem_to_reg_o, mem_read_o, mem_write_o, rs1_o, rs2_o, rd_o,
           valid_o, stall_o, ex_fire_o
  );

endinterface

// File: rtl/ex_hold_cnt.sv
// EX occupancy down-counter: loads on MUL entry, counts to zero, cleared by
// flush; stall is high whenever the count is non-zero.
module ex_hold_cnt
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_flush,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_stall
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  hold_state_e      w_state;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt = '0;
    if (i_flush) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end else if (i_start) begin
      w_cnt_nxt = i_load_val;
    end
  end

  always_comb begin
    w_state = (r_cnt != '0) ? ST_MUL_HOLD : ST_RUN;
    o_stall = (w_state == ST_MUL_HOLD);
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with bubble insertion and, when MUL_HOLD_EN is
// defined, a multi-cycle EX hold for MUL that stalls upstream.
module id_ex_reg
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter int unsigned REG_AW  = REG_AW_DEFAULT,
  parameter int unsigned MUL_LAT = 3
) (
  input logic        clk_i,
  input logic        rst_i,
  id_ex_reg_if.slave bus
);

  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("id_ex_reg: MUL_LAT must be in 1..15");
  end

  ctrl_t             r_ctrl;
  ctrl_t             w_ctrl_in;
  logic              r_valid;
  logic [XLEN-1:0]   r_data1;
  logic [XLEN-1:0]   r_data2;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic              w_stall;
  logic              w_bubble;
  logic              w_load;

  always_comb begin
    w_ctrl_in = '{
      alu_src:    bus.alu_src_i,
      reg_write:  bus.reg_write_i,
      mem_to_reg: bus.mem_to_reg_i,
      mem_read:   bus.mem_read_i,
      mem_write:  bus.mem_write_i,
      alu_ctrl:   alu_op_e'(bus.alu_ctrl_i)
    };
  end

  // Flush beats an active hold; hazard only matters once the hold has drained.
  assign w_bubble = bus.flush_i | (~w_stall & bus.hazard_i);
  assign w_load   = ~bus.flush_i & ~w_stall & ~bus.hazard_i;

`ifdef MUL_HOLD_EN
  localparam logic [3:0] HOLD_LOAD = 4'(MUL_LAT - 1);

  logic w_start;
  assign w_start = w_load & starts_hold(bus.valid_i, bus.alu_ctrl_i);

  ex_hold_cnt #(
    .CNT_W(4)
  ) u_hold (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_flush    (bus.flush_i),
    .i_start    (w_start),
    .i_load_val (HOLD_LOAD),
    .o_stall    (w_stall)
  );
`else
  assign w_stall = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_BUBBLE;
      r_data1 <= '0;
      r_data2 <= '0;
      r_imm   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
    end else if (w_bubble) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_BUBBLE;
      r_data1 <= '0;
      r_data2 <= '0;
      r_imm   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
    end else if (w_load) begin
      r_valid <= bus.valid_i;
      r_ctrl  <= w_ctrl_in;
      r_data1 <= bus.data1_i;
      r_data2 <= bus.data2_i;
      r_imm   <= bus.imm_i;
      r_rs1   <= bus.rs1_i;
      r_rs2   <= bus.rs2_i;
      r_rd    <= bus.rd_i;
    end
  end

  assign bus.valid_o      = r_valid;
  assign bus.alu_src_o    = r_ctrl.alu_src;
  assign bus.reg_write_o  = r_ctrl.reg_write;
  assign bus.mem_to_reg_o = r_ctrl.mem_to_reg;
  assign bus.mem_read_o   = r_ctrl.mem_read;
  assign bus.mem_write_o  = r_ctrl.mem_write;
  assign bus.alu_ctrl_o   = r_ctrl.alu_ctrl;
  assign bus.data1_o      = r_data1;
  assign bus.data2_o      = r_data2;
  assign bus.imm_o        = r_imm;
  assign bus.rs1_o        = r_rs1;
  assign bus.rs2_o        = r_rs2;
  assign bus.rd_o         = r_rd;
  assign bus.stall_o      = w_stall;
  assign bus.ex_fire_o    = r_valid & ~w_stall;

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg: directed scenarios plus randomized traffic checked
// against an occupancy-based model of the EX stage.
module tb_id_ex_reg;

  localparam int LAT = 3;
`ifdef MUL_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  localparam int EXP_LAT = HOLD ? LAT : 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_reg_if #(.XLEN(32), .REG_AW(5)) bus ();

  id_ex_reg #(
    .XLEN    (32),
    .REG_AW  (5),
    .MUL_LAT (LAT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        valid;
    logic        alu_src;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  alu;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } rec_t;

  // Model: the instruction sitting in EX, whether its data is don't-care
  // (bubble), and how many cycles it has already spent there.
  rec_t m_ex;
  bit   m_dc;
  int   m_age;
  int   checks = 0;
  int   errors = 0;

  function automatic rec_t in_rec();
    rec_t r;
    r.valid = bus.valid_i;       r.alu_src = bus.alu_src_i;
    r.reg_write = bus.reg_write_i; r.mem_to_reg = bus.mem_to_reg_i;
    r.mem_read = bus.mem_read_i; r.mem_write = bus.mem_write_i;
    r.alu = bus.alu_ctrl_i;      r.d1 = bus.data1_i; r.d2 = bus.data2_i;
    r.imm = bus.imm_i;           r.rs1 = bus.rs1_i; r.rs2 = bus.rs2_i; r.rd = bus.rd_i;
    return r;
  endfunction

  function automatic rec_t out_rec();
    rec_t r;
    r.valid = bus.valid_o;       r.alu_src = bus.alu_src_o;
    r.reg_write = bus.reg_write_o; r.mem_to_reg = bus.mem_to_reg_o;
    r.mem_read = bus.mem_read_o; r.mem_write = bus.mem_write_o;
    r.alu = bus.alu_ctrl_o;      r.d1 = bus.data1_o; r.d2 = bus.data2_o;
    r.imm = bus.imm_o;           r.rs1 = bus.rs1_o; r.rs2 = bus.rs2_o; r.rd = bus.rd_o;
    return r;
  endfunction

  function automatic rec_t care();
    rec_t c;
    c = '1;
    if (m_dc) begin
      c = '0;
      c.valid = 1'b1; c.reg_write = 1'b1; c.mem_read = 1'b1; c.mem_write = 1'b1;
      c.alu = 3'b111;
    end
    return c;
  endfunction

  // A valid MUL keeps EX busy until it has been there LAT cycles.
  function automatic bit m_stall();
    return HOLD && m_ex.valid && (m_ex.alu == 3'b101) && (m_age < LAT - 1);
  endfunction

  task automatic model_reset();
    m_ex = '0; m_dc = 1'b0; m_age = 0;
  endtask

  task automatic model_edge();
    if (bus.flush_i) begin
      m_ex = '0; m_dc = 1'b1; m_age = 0;
    end else if (m_stall()) begin
      m_age++;
    end else if (bus.hazard_i) begin
      m_ex = '0; m_dc = 1'b1; m_age = 0;
    end else begin
      m_ex = in_rec(); m_dc = 1'b0; m_age = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ctl = {alu_src, reg_write, mem_to_reg, mem_read, mem_write}
  task automatic drive(input logic v, input logic [2:0] alu, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [4:0] ctl);
    bus.valid_i = v; bus.alu_ctrl_i = alu;
    bus.data1_i = d1; bus.data2_i = d2; bus.imm_i = imm;
    bus.rs1_i = rs1; bus.rs2_i = rs2; bus.rd_i = rd;
    {bus.alu_src_i, bus.reg_write_i, bus.mem_to_reg_i, bus.mem_read_i, bus.mem_write_i} = ctl;
  endtask

  task automatic test_reset();
    drive(1'b1, 3'b011, 32'hdead_beef, 32'h1234_5678, 32'hffff_fff0, 5'd1, 5'd2, 5'd3, 5'b11111);
    step();
    drive(1'b1, 3'b101, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 5'd4, 5'd5, 5'd6, 5'b01000);
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_rec() !== '0) begin
      errors++; $display("FAIL reset_fields got=%h want=0", out_rec());
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL reset_stall got=%b want=0", bus.stall_o);
    end
    checks++;
    if (bus.ex_fire_o !== 1'b0) begin
      errors++; $display("FAIL reset_fire got=%b want=0", bus.ex_fire_o);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_rec(), bus.stall_o} !== '0) begin
      errors++; $display("FAIL reset_held got=%h stall=%b want=0", out_rec(), bus.stall_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    rec_t e;
    drive(1'b1, 3'b011, 32'd5, 32'd7, 32'd0, 5'd0, 5'd0, 5'd3, 5'b01000);
    step();
    e = '0; e.valid = 1'b1; e.reg_write = 1'b1; e.alu = 3'b011;
    e.d1 = 32'd5; e.d2 = 32'd7; e.rd = 5'd3;
    checks++;
    if (out_rec() !== e) begin
      errors++; $display("FAIL add_fields got=%h want=%h", out_rec(), e);
    end
    checks++;
    if (bus.ex_fire_o !== 1'b1) begin
      errors++; $display("FAIL add_fire got=%b want=1", bus.ex_fire_o);
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL add_stall got=%b want=0", bus.stall_o);
    end
  endtask

  task automatic test_mul_hold();
    drive(1'b1, 3'b101, 32'd9, 32'd4, 32'd0, 5'd1, 5'd2, 5'd7, 5'b01000);
    step();
    drive(1'b1, 3'b011, 32'd100, 32'd200, 32'd0, 5'd8, 5'd9, 5'd10, 5'b01000);
    for (int i = 0; i < EXP_LAT; i++) begin
      checks++;
      if (bus.rd_o !== 5'd7 || bus.alu_ctrl_o !== 3'b101 || bus.data1_o !== 32'd9) begin
        errors++;
        $display("FAIL mul_hold_fields cyc=%0d got rd=%0d alu=%b d1=%0d want rd=7 alu=101 d1=9",
                 i, bus.rd_o, bus.alu_ctrl_o, bus.data1_o);
      end
      checks++;
      if (bus.stall_o !== (i < EXP_LAT - 1)) begin
        errors++; $display("FAIL mul_hold_stall cyc=%0d got=%b want=%b", i, bus.stall_o, i < EXP_LAT - 1);
      end
      checks++;
      if (bus.ex_fire_o !== (i == EXP_LAT - 1)) begin
        errors++; $display("FAIL mul_hold_fire cyc=%0d got=%b want=%b", i, bus.ex_fire_o, i == EXP_LAT - 1);
      end
      step();
    end
    checks++;
    if (bus.alu_ctrl_o !== 3'b011 || bus.rd_o !== 5'd10 || bus.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL mul_next_capture got alu=%b rd=%0d v=%b want alu=011 rd=10 v=1",
               bus.alu_ctrl_o, bus.rd_o, bus.valid_o);
    end
  endtask

  task automatic test_hazard();
    drive(1'b1, 3'b011, 32'd1, 32'd2, 32'd3, 5'd4, 5'd5, 5'd6, 5'b01011);
    bus.hazard_i = 1'b1;
    step();
    bus.hazard_i = 1'b0;
    checks++;
    if ({bus.valid_o, bus.reg_write_o, bus.mem_read_o, bus.mem_write_o, bus.alu_ctrl_o} !== 7'd0) begin
      errors++;
      $display("FAIL hazard_bubble got v=%b rw=%b mr=%b mw=%b alu=%b want all 0",
               bus.valid_o, bus.reg_write_o, bus.mem_read_o, bus.mem_write_o, bus.alu_ctrl_o);
    end
    checks++;
    if (bus.ex_fire_o !== 1'b0) begin
      errors++; $display("FAIL hazard_fire got=%b want=0", bus.ex_fire_o);
    end
  endtask

  task automatic test_flush_hold();
    drive(1'b1, 3'b101, 32'd3, 32'd3, 32'd0, 5'd1, 5'd1, 5'd2, 5'b01000);
    step();
    drive(1'b1, 3'b011, 32'd6, 32'd6, 32'd0, 5'd3, 5'd3, 5'd9, 5'b01000);
    bus.flush_i  = 1'b1;
    bus.hazard_i = 1'b1;
    step();
    bus.flush_i  = 1'b0;
    bus.hazard_i = 1'b0;
    checks++;
    if ({bus.valid_o, bus.reg_write_o, bus.mem_write_o, bus.alu_ctrl_o, bus.stall_o} !== 7'd0) begin
      errors++;
      $display("FAIL flush_bubble got v=%b rw=%b mw=%b alu=%b stall=%b want all 0",
               bus.valid_o, bus.reg_write_o, bus.mem_write_o, bus.alu_ctrl_o, bus.stall_o);
    end
    step();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.alu_ctrl_o !== 3'b011 || bus.rd_o !== 5'd9 || bus.ex_fire_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_resume got v=%b alu=%b rd=%0d fire=%b want v=1 alu=011 rd=9 fire=1",
               bus.valid_o, bus.alu_ctrl_o, bus.rd_o, bus.ex_fire_o);
    end
  endtask

  task automatic test_back_to_back();
    int fires = 0;
    for (int c = 0; c < 4 * EXP_LAT; c++) begin
      drive(1'b1, 3'b101, $urandom, $urandom, 32'd0, 5'd1, 5'd2, 5'(c + 1), 5'b01000);
      step();
      if (bus.ex_fire_o === 1'b1) fires++;
      checks++;
      if ((out_rec() & care()) !== (m_ex & care()) || bus.stall_o !== m_stall()) begin
        errors++;
        $display("FAIL b2b_state cyc=%0d got=%h stall=%b want=%h stall=%b",
                 c, out_rec(), bus.stall_o, m_ex, m_stall());
      end
    end
    checks++;
    if (fires !== 4) begin
      errors++; $display("FAIL b2b_fire_count got=%0d want=4", fires);
    end
  endtask

  task automatic test_random();
    logic [2:0] alu;
    for (int n = 0; n < 400; n++) begin
      bus.flush_i  = ($urandom_range(0, 15) == 0);
      bus.hazard_i = ($urandom_range(0, 7) == 0);
      alu = ($urandom_range(0, 2) == 0) ? 3'b101 : 3'($urandom_range(0, 6));
      drive($urandom_range(0, 3) != 0, alu, $urandom, $urandom, $urandom,
            5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      step();
      checks++;
      if ((out_rec() & care()) !== (m_ex & care())) begin
        errors++; $display("FAIL rand_fields n=%0d got=%h want=%h dc=%b", n, out_rec(), m_ex, m_dc);
      end
      checks++;
      if (bus.stall_o !== m_stall()) begin
        errors++; $display("FAIL rand_stall n=%0d got=%b want=%b", n, bus.stall_o, m_stall());
      end
      checks++;
      if (bus.ex_fire_o !== (m_ex.valid && !m_stall())) begin
        errors++; $display("FAIL rand_fire n=%0d got=%b want=%b", n, bus.ex_fire_o, m_ex.valid && !m_stall());
      end
    end
    bus.flush_i  = 1'b0;
    bus.hazard_i = 1'b0;
  endtask

  initial begin
    bus.flush_i  = 1'b0;
    bus.hazard_i = 1'b0;
    drive(1'b0, 3'b000, '0, '0, '0, '0, '0, '0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_add();
    test_mul_hold();
    test_hazard();
    test_flush_hold();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register. Captures decoded operands, immediate, ALU control code and downstream control bits from the decode stage, and presents them to the ALU and EX-stage muxes.
- Inserts bubbles on hazard or flush.
- Holds a MUL instruction in EX for a configurable number of cycles, asserting stall upstream and gating the EX/MEM capture.

Parameters:
- XLEN, 32, operand/immediate width
- REG_AW, 5, register-index width
- MUL_LAT, 3, EX-occupancy cycles for ALUCtrl=MUL (101); legal range 1..15

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- hazard_i  in  1  load-use hazard from hazard unit; load a bubble
- flush_i  in  1  pipeline flush; load a bubble and abort any MUL hold
- valid_i  in  1  decode stage holds a real instruction
- data1_i  in  XLEN  rs1 value
- data2_i  in  XLEN  rs2 value
- imm_i  in  XLEN  sign-extended immediate
- alu_ctrl_i  in  3  ALU code (000 AND, 001 XOR, 010 SLL, 011 ADD, 100 SUB, 101 MUL, 110 SRAI)
- alu_src_i, reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i  in  1 each  control bits
- rs1_i, rs2_i, rd_i  in  REG_AW each  register indices
- Outputs: the same fields with the _o suffix, registered, same widths, plus the two below
- valid_o  out  1  EX holds a real instruction
- stall_o  out  1  EX occupied by MUL; IF/ID and PC must hold
- ex_fire_o  out  1  valid_o & ~stall_o; EX/MEM captures only when high

Behaviour:
- Reset (rst_i low, async):
  - all registered outputs go to 0, which is a bubble: alu_ctrl_o=000, every control bit 0, valid_o=0.
  - Hold counter goes to 0, so stall_o=0 and ex_fire_o=0.
- Register latency is 1 cycle. Inputs present at edge N are visible on the outputs after edge N.
- State: the hold counter cnt[3:0]. RUN when cnt==0; MUL_HOLD when cnt!=0. stall_o = (cnt!=0), combinational from cnt.
- Per-edge priority, highest first:
  1. flush_i=1: load a bubble and set cnt=0. Flush wins over a MUL hold and over hazard_i.
  2. cnt!=0: hold every field, cnt-=1, ignore hazard_i and valid_i. Decode is frozen by stall_o, so nothing is lost.
  3. hazard_i=1: load a bubble; data fields may load but are don't-care; cnt stays 0.
  4. Otherwise: load all inputs and set valid_o=valid_i.
     - If valid_i=1 and alu_ctrl_i=101, set cnt=MUL_LAT-1.
     - Otherwise cnt stays 0.
- Bubble definition: valid_o=0, reg_write_o=0, mem_read_o=0, mem_write_o=0, alu_ctrl_o=000. Data and index fields are don't-care; the implementation zeroes them.
- A MUL with valid_i=0 never starts a hold.
- MUL_LAT=1: no hold ever occurs, stall_o is constantly 0, and MUL completes in one cycle like the other ops.
- A MUL enters on edge N, and stall_o is high for the MUL_LAT-1 cycles that follow. ex_fire_o goes high in the final cycle, exactly MUL_LAT cycles after entry.
- Back-to-back MULs: the second MUL is presented but not captured until cnt reaches 0. It then captures and starts a fresh hold, with no gap cycle.
- Reset asserted mid-hold clears cnt immediately; there is no residual stall.

Optional Feature:
- MUL_HOLD_EN
- Defined: multi-cycle MUL hold as specified above.
- Undefined: cnt logic is removed, stall_o is tied to 0, ex_fire_o = valid_o, and the MUL_LAT parameter is ignored. The register becomes a plain pipeline latch with bubble insertion.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU code constants: ALU_AND, ALU_XOR, ALU_SLL, ALU_ADD, ALU_SUB, ALU_MUL, ALU_SRAI.
  - XLEN and REG_AW defaults.
  - A packed control-bundle typedef ctrl_t (alu_src, reg_write, mem_to_reg, mem_read, mem_write, alu_ctrl) and the constant CTRL_BUBBLE.
- One natural sub-module, ex_hold_cnt: the down-counter with load, flush-clear and stall_o output, instantiated only under MUL_HOLD_EN.

Test Plan:
- Reset: drive rst_i low mid-cycle with valid inputs present -> all outputs 0 immediately, without waiting for a clock edge; stall_o=0.
- ADD pass-through: alu_ctrl_i=011, data1=5, data2=7, rd=3, reg_write=1, valid=1 -> next cycle outputs match the inputs, valid_o=1, ex_fire_o=1, stall_o=0.
- MUL hold, MUL_LAT=3: MUL enters on edge 0 -> stall_o=1 for cycles 1-2; fields unchanged while a different instruction is on the inputs; ex_fire_o=1 only in cycle 3; the following instruction captures on edge 3.
- Hazard: hazard_i=1 with a valid ADD on the inputs -> valid_o=0, reg_write_o=0, mem_write_o=0, alu_ctrl_o=000 next cycle.
- Flush during hold: MUL enters, flush_i=1 on the first hold edge -> bubble, stall_o=0 the next cycle; a hazard_i asserted in the same cycle has no extra effect.
- Macro off / MUL_LAT=1: MUL enters -> stall_o never rises; ex_fire_o=1 the next cycle; back-to-back MULs issue every cycle.
